// File: rtl/cond_flag_unit.sv
// -----------------------------------------------------------------------------
// cond_flag_unit
//
// Condition-evaluation and NZCV status register for the ID stage. Holds the
// architectural flags and evaluates LANES 4-bit ARM condition fields against
// them every cycle. It also counts flag-setting instructions that have issued
// but not yet written NZCV back, and stalls issue of any predicated
// instruction that would otherwise read stale flags.
//
// Optional feature macro: FLAG_BYPASS_EN
//   defined   : sr_wdata is forwarded into condition evaluation in the cycle
//               it is written, so the sole in-flight setter's write-back cycle
//               does not stall.
//   undefined : evaluation always uses the registered sr.
//
// Parameters
//   LANES       number of condition fields evaluated per cycle
//   PEND_DEPTH  maximum in-flight flag setters (>= 1)
//   CNT_W       pending counter width (derived from PEND_DEPTH)
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   cond           in   condition fields, lane k at [4k+3:4k]
//   iss_valid      in   ID presents an instruction
//   iss_sets_flags in   presented instruction will write NZCV later
//   sr_we          in   EXE writes NZCV this cycle
//   sr_wdata       in   new NZCV value {N,Z,C,V}
//   flush          in   discard all in-flight flag setters
//   cCheck         out  per-lane condition pass
//   sr             out  architectural NZCV
//   stall          out  hold ID, instruction not accepted
//   pend_cnt       out  number of in-flight flag setters
//
// Issue handshake: iss_valid is the request and !stall is the ready. An
// instruction is accepted in exactly the cycle where iss_valid=1 and stall=0;
// when stall=1 the instruction is not taken and ID must present it again.
// stall may be high while iss_valid is low only never; both hazard and full
// terms are qualified by iss_valid.
// -----------------------------------------------------------------------------
module cond_flag_unit #(
    parameter int LANES      = 1,
    parameter int PEND_DEPTH = 2,
    parameter int CNT_W      = $clog2(PEND_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*LANES-1:0] cond,
    input  logic               iss_valid,
    input  logic               iss_sets_flags,
    input  logic               sr_we,
    input  logic [3:0]         sr_wdata,
    input  logic               flush,
    output logic [LANES-1:0]   cCheck,
    output logic [3:0]         sr,
    output logic               stall,
    output logic [CNT_W-1:0]   pend_cnt
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PEND_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [3:0] eff_flags;
    logic       wb_release;
    logic       any_dep;
    logic       pend_nz;
    logic       hazard;
    logic       full;
    logic       accept;
    logic       inc;
    logic       dec;

    // Codes come in true/inverted pairs: c[3:1] selects the base test and
    // c[0] inverts it. Pair 111 (AL and 1111) always passes.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cf;
        logic v;
        logic base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = n ~^ v;
            3'd6:    base = ~z & (n ~^ v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
    endfunction

`ifdef FLAG_BYPASS_EN
    // The value being written this cycle is the freshest flag state.
    assign eff_flags  = sr_we ? sr_wdata : sr;
    // The only outstanding setter retires now and its result is forwarded.
    assign wb_release = sr_we & (pend_cnt == ONE_C);
`else
    assign eff_flags  = sr;
    assign wb_release = 1'b0;
`endif

    always_comb begin
        cCheck  = '0;
        any_dep = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            cCheck[k] = eval_cond(cond[4*k +: 4], eff_flags);
            if (cond[4*k+1 +: 3] != 3'b111) begin
                any_dep = 1'b1;
            end
        end
    end

    assign pend_nz = (pend_cnt != '0);
    assign hazard  = iss_valid & any_dep & pend_nz & ~wb_release;
    // A write-back in the same cycle frees a slot, so a full counter only
    // blocks a new setter when nothing retires.
    assign full    = iss_valid & iss_sets_flags & (pend_cnt == DEPTH_C) & ~sr_we;
    assign stall   = hazard | full;
    assign accept  = iss_valid & ~stall;
    assign inc     = accept & iss_sets_flags;
    assign dec     = sr_we & pend_nz;

    // sr follows every write, including MSR-style writes with nothing pending
    // and writes that coincide with flush or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= 4'b0000;
        end else if (sr_we) begin
            sr <= sr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else if (flush) begin
            pend_cnt <= '0;
        end else if (inc && !dec) begin
            pend_cnt <= pend_cnt + ONE_C;
        end else if (dec && !inc) begin
            pend_cnt <= pend_cnt - ONE_C;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [4*LANES-1:0] cond;
  logic               iss_valid;
  logic               iss_sets_flags;
  logic               sr_we;
  logic [3:0]         sr_wdata;
  logic               flush;
  logic [LANES-1:0]   cCheck;
  logic [3:0]         sr;
  logic               stall;
  logic [CNT_W-1:0]   pend_cnt;

  int checks = 0;
  int errors = 0;

  // reference state: what the registers should hold right now
  int         m_pend;
  logic [3:0] m_sr;

  cond_flag_unit #(.LANES(LANES), .PEND_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cond           (cond),
    .iss_valid      (iss_valid),
    .iss_sets_flags (iss_sets_flags),
    .sr_we          (sr_we),
    .sr_wdata       (sr_wdata),
    .flush          (flush),
    .cCheck         (cCheck),
    .sr             (sr),
    .stall          (stall),
    .pend_cnt       (pend_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // condition table straight from the ARM condition list
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] c,
                       input logic we, input logic [3:0] wd, input logic fl);
    iss_valid      = v;
    iss_sets_flags = s;
    cond           = c;
    sr_we          = we;
    sr_wdata       = wd;
    flush          = fl;
  endtask

  // one clock: predict, check at negedge, then advance the model at posedge
  task automatic cycle();
    logic [3:0] eff;
    logic [1:0] cc_e;
    logic dep, haz, full_c, stall_e, acc;
    int inc, dec;
    eff     = (BYP && sr_we) ? sr_wdata : m_sr;
    cc_e[0] = ref_cond(cond[3:0], eff);
    cc_e[1] = ref_cond(cond[7:4], eff);
    dep     = (cond[3:0] < 4'd14) || (cond[7:4] < 4'd14);
    haz     = iss_valid && dep && (m_pend > 0) && !(BYP && m_pend == 1 && sr_we);
    full_c  = iss_valid && iss_sets_flags && (m_pend == DEPTH) && !sr_we;
    stall_e = haz || full_c;
    @(negedge clk);
    check("stall",    32'(stall),    32'(stall_e));
    check("cCheck",   32'(cCheck),   32'(cc_e));
    check("sr",       32'(sr),       32'(m_sr));
    check("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    @(posedge clk);
    acc = iss_valid && !stall_e;
    inc = (acc && iss_sets_flags) ? 1 : 0;
    dec = (sr_we && m_pend > 0) ? 1 : 0;
    if (sr_we) m_sr = sr_wdata;
    if (flush) m_pend = 0;
    else       m_pend = m_pend + inc - dec;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_pend = 0;
    m_sr = 4'b0000;
    drive(0, 0, 8'hEE, 0, 4'h0, 0);

    // reset state, observed mid-cycle while reset is held
    #3;
    check("rst_sr",   32'(sr),       32'h0);
    check("rst_pend", 32'(pend_cnt), 32'h0);
    check("rst_stall", 32'(stall),   32'h0);
    cond = 8'hE1;
    #1;
    check("rst_ne", 32'(cCheck), 32'h3);
    cond = 8'hE0;
    #1;
    check("rst_eq", 32'(cCheck), 32'h2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // every code against every NZCV value written with nothing pending
    for (int f = 0; f < 16; f++) begin
      drive(0, 0, 8'hEE, 1, 4'(f), 0);
      cycle();
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, {4'(15 - c), 4'(c)}, 0, 4'h0, 0);
        cycle();
      end
    end

    // S issue followed by dependent EQ during its write-back
    drive(0, 0, 8'hEE, 1, 4'h0, 0);
    cycle();
    drive(1, 1, 8'hEE, 0, 4'h0, 0);
    cycle();
    drive(1, 0, 8'hE0, 1, 4'b0100, 0);
    cycle();
    drive(1, 0, 8'hE0, 0, 4'h0, 0);
    cycle();
    check("eq_after_wb", 32'(cCheck[0]), 32'h1);

    // three S issues without write-back: the third is held at the limit
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'hEE, 0, 4'h0, 0);
      cycle();
    end
    check("full_hold", 32'(pend_cnt), 32'(DEPTH));
    // same issue alongside a write-back: accepted, counter unchanged
    drive(1, 1, 8'hEE, 1, 4'h3, 0);
    cycle();
    check("full_swap", 32'(pend_cnt), 32'(DEPTH));

    // flush beats a simultaneous accepted S issue
    drive(1, 1, 8'hEE, 1, 4'h5, 1);
    cycle();
    drive(0, 0, 8'hEE, 0, 4'h0, 0);
    cycle();

    // two lanes: one dependent lane stalls, two independent lanes do not
    drive(1, 1, 8'hEE, 0, 4'h0, 0);
    cycle();
    drive(1, 0, 8'hE0, 0, 4'h0, 0);
    cycle();
    drive(1, 0, 8'hEF, 0, 4'h0, 0);
    cycle();

    // reset while a setter is in flight discards it
    drive(0, 0, 8'hEE, 1, 4'hF, 0);
    cycle();
    drive(1, 1, 8'hEE, 0, 4'h0, 0);
    cycle();
    drive(0, 0, 8'hEE, 0, 4'h0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sr",   32'(sr),       32'h0);
    check("mid_rst_pend", 32'(pend_cnt), 32'h0);
    m_pend = 0;
    m_sr = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1, 8'hE1, 0, 4'h0, 0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] l0, l1;
      l0 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      l1 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {l1, l0},
            1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Parametrised condition-evaluation and status-register block for the ID stage of the 32-bit ARM pipeline. Holds the architectural NZCV register, evaluates LANES condition fields per cycle against it, and tracks in-flight flag-setting instructions so a predicated instruction is never evaluated against stale flags. When a predicated instruction would read stale flags, the block stalls issue; with the bypass option enabled, it instead forwards the flag value being written in the same cycle.

## Interface
- LANES, default 1: number of 4-bit condition fields evaluated per cycle.
- PEND_DEPTH, default 2: maximum flag-setting instructions in flight between issue and flag write-back (≥1).
- CNT_W, default $clog2(PEND_DEPTH+1): width of the pending counter; derived, not overridden.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cond  in  4*LANES  condition field per lane; lane k at bits [4k+3:4k].
- iss_valid  in  1  ID presents an instruction for issue this cycle.
- iss_sets_flags  in  1  the presented instruction has S=1 and will write NZCV later.
- sr_we  in  1  EXE writes NZCV this cycle.
- sr_wdata  in  4  new NZCV, bit order {N,Z,C,V}.
- flush  in  1  pipeline flush; discards in-flight flag setters.
- cCheck  out  LANES  per-lane condition pass.
- sr  out  4  architectural NZCV.
- stall  out  1  hold ID; instruction not accepted.
- pend_cnt  out  CNT_W  current number of in-flight flag setters.

## Operation
- Condition decode per lane, {N,Z,C,V}:
  - EQ 0000 → Z; NE 0001 → !Z.
  - CS 0010 → C; CC 0011 → !C.
  - MI 0100 → N; PL 0101 → !N.
  - VS 0110 → V; VC 0111 → !V.
  - HI 1000 → C&!Z; LS 1001 → !C|Z.
  - GE 1010 → N==V; LT 1011 → N!=V.
  - GT 1100 → !Z&(N==V); LE 1101 → Z|(N!=V).
  - AL 1110 → 1; 1111 → 1.
- Flag-independent lane: a lane whose condition is 1110 or 1111.
- Effective flags: equal to sr. With bypass, equal to sr_wdata when sr_we=1 in the same cycle.
- Hazard: iss_valid=1, any lane flag-dependent, and pend_cnt>0. Without bypass this raises stall. With bypass it raises stall unless pend_cnt==1 and sr_we=1.
- Full: iss_valid=1, iss_sets_flags=1, and pend_cnt==PEND_DEPTH with no sr_we this cycle. Full raises stall.
- stall = hazard | full.
- Accept = iss_valid & !stall.
- Pending counter next value:
  - flush=1 → 0, overriding everything else.
  - Otherwise, inc = accept & iss_sets_flags and dec = sr_we & (pend_cnt>0).
  - inc and dec together → unchanged. Only inc → +1. Only dec → −1.
- sr_we with pend_cnt==0 (MSR-style write) updates sr; the counter stays at 0.
- sr loads sr_wdata on every sr_we, including during flush and stall.
- cCheck is driven from the effective flags even when stall=1. The consumer ignores it when stalled.

## Timing
- cCheck, stall: combinational from cond, iss_*, sr_we, sr_wdata, sr, pend_cnt. Zero-cycle latency.
- sr, pend_cnt: registered, updated at rising clk. A write at edge t is visible to cCheck from cycle t+1, or in cycle t with bypass.
- Reset, asynchronous on rst_n low: sr=4'b0000, pend_cnt=0. Outputs follow immediately: stall=0 unless full/hazard, and cCheck reflects flags 0000.
- Reset asserted mid-operation discards all pending state. The first edge after rst_n rises behaves as from idle.
- Counter never exceeds PEND_DEPTH and never underflows.

## Configuration
- FLAG_BYPASS_EN defined: same-cycle forwarding of sr_wdata into the condition evaluation. Removes the one-cycle stall when the sole in-flight setter writes back in the same cycle.
- FLAG_BYPASS_EN undefined: the condition evaluation always uses the registered sr. Any flag-dependent lane stalls while pend_cnt>0, including the write-back cycle.

## Test plan
- Reset: rst_n=0 mid-cycle → sr=0000 and pend_cnt=0 immediately. cond=0001 (NE) gives cCheck=1; cond=0000 gives cCheck=0.
- All 16 codes × all 16 NZCV values via sr_we with pend_cnt=0 → cCheck matches the decode list, e.g. NZCV=1001 with GE=1 and LT=0, NZCV=0110 with HI=0 and LS=1.
- Issue S-instruction, then next cycle cond=0000 with sr_we=1 and sr_wdata=0100:
  - Without the macro, stall=1 for one cycle, then cCheck=1.
  - With FLAG_BYPASS_EN, stall=0 and cCheck=1 in the same cycle.
- PEND_DEPTH=2, three consecutive S issues with no write-back → third cycle stall=1 and pend_cnt stays 2. An sr_we in that third cycle → no stall, pend_cnt stays 2.
- pend_cnt=2, flush=1 with simultaneous accepted S issue → pend_cnt=0 next cycle.
- LANES=2, cond={1110,0000}, pend_cnt=1, no sr_we → stall=1. With cond={1110,1111} → stall=0 and cCheck=2'b11.
